// File: rtl/and2_bist_ctrl.sv
// BIST sequencer for the and2 gate: sweeps {a,b} through 00..11 for PASSES
// passes, samples y/z after SETTLE extra cycles and reports pass/fail status.
module and2_bist_ctrl #(
   parameter int unsigned PASSES = 2,
   parameter int unsigned SETTLE = 1,
   parameter int unsigned ERR_W  = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic             a,
   output logic             b,
   input  logic             y,
   input  logic             z,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_cnt,
   output logic             fail_valid,
   output logic [1:0]       fail_vec
);

   localparam int unsigned CNT_W  = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
   localparam int unsigned PCNT_W = (PASSES > 1) ? $clog2(PASSES) : 1;
   localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t              state_q, state_d;
   logic [1:0]          vec_q, vec_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [PCNT_W-1:0]   pcnt_q, pcnt_d;
   logic                a_q, a_d, b_q, b_d;
   logic                busy_q, busy_d, done_q, done_d, pass_q, pass_d;
   logic [ERR_W-1:0]    err_cnt_q, err_cnt_d;
   logic                fail_valid_q, fail_valid_d;
   logic [1:0]          fail_vec_q, fail_vec_d;
   logic                mismatch;

   // Next-state, vector sequencing and result accumulation
   always_comb begin
      state_d      = state_q;
      vec_d        = vec_q;
      cnt_d        = cnt_q;
      pcnt_d       = pcnt_q;
      a_d          = 1'b0;
      b_d          = 1'b0;
      busy_d       = 1'b0;
      done_d       = 1'b0;
      pass_d       = pass_q;
      err_cnt_d    = err_cnt_q;
      fail_valid_d = fail_valid_q;
      fail_vec_d   = fail_vec_q;
      mismatch     = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d      = S_RUN;
               vec_d        = 2'd0;
               cnt_d        = '0;
               pcnt_d       = '0;
               busy_d       = 1'b1;
               pass_d       = 1'b0;
               err_cnt_d    = '0;
               fail_valid_d = 1'b0;
               fail_vec_d   = 2'd0;
            end
         end
         S_RUN: begin
            busy_d = 1'b1;
            if (cnt_q == CNT_W'(SETTLE)) begin
               // One mismatch per sample, even if both outputs are wrong
               mismatch = (y != (a_q & b_q)) || (z != (a_q | b_q));
               if (mismatch) begin
                  if (err_cnt_q != ERR_MAX) err_cnt_d = err_cnt_q + ERR_W'(1);
                  if (!fail_valid_q) begin
                     fail_valid_d = 1'b1;
                     fail_vec_d   = {a_q, b_q};
                  end
               end
               cnt_d = '0;
               vec_d = vec_q + 2'd1;
               if (vec_q == 2'd3) begin
                  pcnt_d = pcnt_q + PCNT_W'(1);
                  if (pcnt_q == PCNT_W'(PASSES - 1)) begin
                     state_d = S_DONE;
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                     pass_d  = (err_cnt_d == '0) && !fail_valid_d;
                  end
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Gate inputs follow the vector only while a test is running
      if (state_d == S_RUN) begin
         a_d = vec_d[1];
         b_d = vec_d[0];
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         vec_q        <= 2'd0;
         cnt_q        <= '0;
         pcnt_q       <= '0;
         a_q          <= 1'b0;
         b_q          <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
         err_cnt_q    <= '0;
         fail_valid_q <= 1'b0;
         fail_vec_q   <= 2'd0;
      end else begin
         state_q      <= state_d;
         vec_q        <= vec_d;
         cnt_q        <= cnt_d;
         pcnt_q       <= pcnt_d;
         a_q          <= a_d;
         b_q          <= b_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         pass_q       <= pass_d;
         err_cnt_q    <= err_cnt_d;
         fail_valid_q <= fail_valid_d;
         fail_vec_q   <= fail_vec_d;
      end
   end

   assign a          = a_q;
   assign b          = b_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign pass       = pass_q;
   assign err_cnt    = err_cnt_q;
   assign fail_valid = fail_valid_q;
   assign fail_vec   = fail_vec_q;

endmodule

// File: doc/and2_bist_ctrl.md
# and2_bist_ctrl

Built-in self-test sequencer for the two-input AND/OR gate block (`and2`: inputs `a`, `b`; outputs `y` = AND, `z` = OR). On a start pulse it drives the gate's inputs through all four input combinations for a configurable number of passes. It samples `y` and `z` after a programmable settle time, compares them against the expected values, and reports a pass/fail flag, a saturating mismatch count and the first failing vector. It sits beside the gate and owns its input pins while a test is running.

## Interface
Parameters:
- `PASSES`, default 2: number of full 4-vector sweeps per test; must be ≥1.
- `SETTLE`, default 1: extra cycles each vector is held before sampling; ≥0.
- `ERR_W`, default 8: width of the mismatch counter.

Ports:
- `clk`, in, 1: single clock; all logic is rising-edge.
- `rst_n`, in, 1: asynchronous active-low reset.
- `start`, in, 1: test request, sampled in IDLE only.
- `a`, out, 1: drive to gate input a.
- `b`, out, 1: drive to gate input b.
- `y`, in, 1: gate AND output.
- `z`, in, 1: gate OR output.
- `busy`, out, 1: test in progress.
- `done`, out, 1: one-cycle pulse at test end.
- `pass`, out, 1: 1 when the last test had zero mismatches.
- `err_cnt`, out, ERR_W: number of mismatching vector samples, saturating.
- `fail_valid`, out, 1: at least one mismatch was seen in the last test.
- `fail_vec`, out, 2: {a,b} of the first mismatching sample.

## Operation
- States: IDLE, RUN, DONE.
- **IDLE**
  - `a`=`b`=0 and `busy`=0.
  - When `start`=1, on that edge: go to RUN; vector index `vec`=0; settle count `cnt`=0; pass count `pcnt`=0.
  - The same edge clears `err_cnt`, `fail_valid` and `fail_vec`, and sets `pass`=0.
- **RUN**
  - `busy`=1 and {`a`,`b`}=`vec`, so the order is 00, 01, 10, 11 with `b` as the LSB.
  - Each vector is held for SETTLE+1 cycles; `cnt` counts 0..SETTLE.
  - On the edge where `cnt`==SETTLE, compare `y` against `a&b` and `z` against `a|b`.
  - A sample is a mismatch if either output differs; a sample counts once even if both differ.
  - On a mismatch, `err_cnt` increments, saturating at 2^ERR_W−1.
  - On the first mismatch of a test, `fail_vec`={a,b} and `fail_valid`=1. Later mismatches do not change `fail_vec`.
  - After each sample, `cnt`=0 and `vec` advances; it wraps from 11 to 00 and increments `pcnt`.
  - After the sample of vector 11 on pass PASSES−1, go to DONE.
- **DONE**
  - Lasts exactly one cycle: `done`=1, `busy`=0, `a`=`b`=0.
  - `pass`=(`err_cnt`==0 and no mismatch seen, counting one recorded on the final sample); it is asserted in this cycle.
  - Next state is IDLE.
- `start` in RUN or DONE is ignored and not queued.
- `pass`, `err_cnt`, `fail_valid` and `fail_vec` hold their values in IDLE until the next accepted `start`.
- `rst_n` low at any time, including mid-RUN, immediately forces IDLE and all outputs to their reset values. There is no resumption.

## Timing
- Reset values: `a`=0, `b`=0, `busy`=0, `done`=0, `pass`=0, `err_cnt`=0, `fail_valid`=0, `fail_vec`=00.
- All outputs are registered; `y` and `z` are sampled combinationally-settled at the sampling edge.
- Let edge 0 be the edge where `start` is accepted. `busy` rises after edge 0.
- The last sample happens on edge 4·PASSES·(SETTLE+1). `done` and `pass` are valid in the cycle that follows it.
- With the defaults, `done` is high in the 16th cycle after edge 0.
- `a` and `b` change only on vector boundaries, so there are SETTLE+1 stable cycles before each sample.
- Back-to-back tests: `start` held high through DONE is accepted in the following IDLE cycle. The minimum gap between `done` pulses is 4·PASSES·(SETTLE+1)+2 cycles.

## Test plan
- **Good gate**, defaults, `start` pulse → `a`/`b` sequence 00,01,10,11,00,01,10,11 with each vector held 2 cycles; `done` 16 cycles after start; `pass`=1, `err_cnt`=0, `fail_valid`=0.
- **`y` stuck at 0**, defaults → `err_cnt`=2, `fail_vec`=11, `fail_valid`=1, `pass`=0.
- **`z` stuck at 1**, PASSES=1, SETTLE=0 → `done` in the 4th cycle after start; `err_cnt`=1, `fail_vec`=00.
- **Saturation**: ERR_W=2, `y`=~(a&b), defaults → 8 mismatches saturate `err_cnt` at 3; `fail_vec`=00.
- **`start` reasserted mid-RUN** → ignored; a single `done` at cycle 16. Then `start` again with a good gate → the previous failing results are cleared and `pass`=1.
- **`rst_n` pulsed low at cycle 5 of a run** → immediate `busy`=0, `a`=`b`=0 and all status outputs 0. No `done` pulse follows. A new `start` runs a complete test.
